// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  // Operation codes presented on the op port.
  typedef enum logic [2:0] {
    OpNone  = 3'b000,
    OpMult  = 3'b001,
    OpMultu = 3'b010,
    OpDiv   = 3'b011,
    OpDivu  = 3'b100,
    OpMthi  = 3'b101,
    OpMtlo  = 3'b110
  } mdu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } mdu_state_t;

  // One iteration per operand bit.
  localparam int unsigned MDU_ITERS = 32;

  // Ops that interpret their operands as two's complement.
  function automatic logic mdu_is_signed(input mdu_op_t op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, yielding one quotient bit.
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_ITERS
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_part;
  logic [WIDTH:0] w_diff;

  // Trial subtraction; no borrow means the divisor fits.
  always_comb begin
    w_part = {i_rem, i_bit};
    w_diff = w_part - {1'b0, i_div};
    o_q    = ~w_diff[WIDTH];
    // The remainder stays below the divisor, so the top bit is always zero.
    o_rem  = o_q ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit holding architectural HI/LO.
// Multiply is shift-add, divide is restoring; both run on operand magnitudes
// with the sign applied in the FIX state.
// Build option: define MDU_DIV_EN to build the divider; without it DIV/DIVU
// behave as NONE.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_ITERS,
  parameter int unsigned CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  mdu_state_t       r_state;
  mdu_state_t       w_state_d;
  logic [CNT_W-1:0] r_count;
  // Upper half: partial product / partial remainder; lower half: multiplier /
  // dividend bits shifting out while result bits shift in.
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg_q;
  logic             r_done;
`ifdef MDU_DIV_EN
  logic             r_is_div;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] w_dv_rem;
  logic             w_dv_q;
`endif

  mdu_op_t          w_op;
  logic             w_go_mul;
  logic             w_go_div;
  logic             w_mthi;
  logic             w_mtlo;
  logic             w_signed;
  logic             w_last;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [W2-1:0]    w_acc_step;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH-1:0] w_lo_fix;

  assign w_op     = mdu_op_t'(i_op);
  assign w_signed = mdu_is_signed(w_op);
  assign w_rs_mag = (w_signed && i_rs[WIDTH-1]) ? -i_rs : i_rs;
  assign w_rt_mag = (w_signed && i_rt[WIDTH-1]) ? -i_rt : i_rt;
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  // Decode requests; only honoured in IDLE so start while busy is dropped.
  always_comb begin
    w_go_mul = 1'b0;
    w_go_div = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    if (i_start && (r_state == StIdle)) begin
      case (w_op)
        OpMult, OpMultu: w_go_mul = 1'b1;
`ifdef MDU_DIV_EN
        OpDiv, OpDivu:   w_go_div = 1'b1;
`endif
        OpMthi:          w_mthi   = 1'b1;
        OpMtlo:          w_mtlo   = 1'b1;
        default:         ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_go_mul || w_go_div) w_state_d = StCalc;
      StCalc:  if (w_last) w_state_d = StFix;
      StFix:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

`ifdef MDU_DIV_EN
  mdu_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .i_rem (r_acc[W2-1:WIDTH]),
    .i_bit (r_acc[WIDTH-1]),
    .i_div (r_b),
    .o_rem (w_dv_rem),
    .o_q   (w_dv_q)
  );
`endif

  // One iteration of the active algorithm.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH + 1){1'b0}});
    w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    if (r_is_div) w_acc_step = {w_dv_rem, r_acc[WIDTH-2:0], w_dv_q};
`endif
  end

  // Sign fix-up and final HI/LO values.
  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_hi_fix = w_prod[W2-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (r_is_div) begin
      w_hi_fix = r_neg_r ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];
      // Divide by zero: the remainder path already reproduces rs, LO is forced.
      if (r_div0)       w_lo_fix = '1;
      else if (r_neg_q) w_lo_fix = -r_acc[WIDTH-1:0];
      else              w_lo_fix = r_acc[WIDTH-1:0];
    end
`endif
  end

  // Datapath: operand capture, iteration, HI/LO writes and done pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_done   <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_go_mul) begin
            r_acc    <= {{WIDTH{1'b0}}, w_rt_mag};
            r_b      <= w_rs_mag;
            r_neg_q  <= w_signed && (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
            r_count  <= '0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
`endif
          end
`ifdef MDU_DIV_EN
          if (w_go_div) begin
            r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
            r_b      <= w_rt_mag;
            r_neg_q  <= w_signed && (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
            r_neg_r  <= w_signed && i_rs[WIDTH-1];
            r_div0   <= (i_rt == '0);
            r_is_div <= 1'b1;
            r_count  <= '0;
          end
`endif
          if (w_mthi) r_hi <= i_rs;
          if (w_mtlo) r_lo <= i_rs;
        end
        StCalc: begin
          r_acc   <= w_acc_step;
          r_count <= r_count + 1'b1;
        end
        StFix: begin
          r_hi   <= w_hi_fix;
          r_lo   <= w_lo_fix;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter. Expected HI/LO pairs are queued
// when an operation is issued and compared when the DUT completes it.
// Expectations follow MDU_DIV_EN the same way the design does.
module tb_mdu_iter;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_rs;
  logic [31:0] i_rt;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_iter u_dut (
    .i_clk   (clk),
    .i_rstn  (i_rstn),
    .i_start (i_start),
    .i_op    (i_op),
    .i_rs    (i_rs),
    .i_rt    (i_rt),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Arithmetic reference for the architectural result of one op.
  function automatic res_t model(input logic [2:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input res_t cur);
    res_t   r;
    longint p;
    int     a;
    int     b;
    r = cur;
    case (op)
      OP_MULT: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        r = p;
      end
      OP_MULTU: r = {32'b0, rs} * {32'b0, rt};
`ifdef MDU_DIV_EN
      OP_DIV: begin
        a = $signed(rs);
        b = $signed(rt);
        if (rt == 0)                                   r = {rs, 32'hFFFF_FFFF};
        else if (rs == 32'h8000_0000 && rt == '1)      r = {32'h0, 32'h8000_0000};
        else                                           r = {32'(a % b), 32'(a / b)};
      end
      OP_DIVU: begin
        if (rt == 0) r = {rs, 32'hFFFF_FFFF};
        else         r = {rs % rt, rs / rt};
      end
`endif
      OP_MTHI: r.hi = rs;
      OP_MTLO: r.lo = rs;
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input bit now);
    if (!now) @(negedge clk);
    i_start = 1'b1;
    i_op    = op;
    i_rs    = rs;
    i_rt    = rt;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_op    = OP_NONE;
  endtask

  // Waits for done, counting busy cycles; optionally injects an op mid-flight.
  task automatic wait_done(input string tag, input int inj_at, input logic [2:0] inj_op,
                           input logic [31:0] inj_rs);
    int   n_busy = 0;
    bit   seen   = 1'b0;
    res_t exp;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (inj_at >= 0 && c == inj_at + 1) begin
        i_start = 1'b0;
        i_op    = OP_NONE;
        chk({tag, "_hold"}, {o_hi, o_lo}, {m_hi, m_lo});
      end
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_busy) n_busy++;
      if (c == inj_at) begin
        i_start = 1'b1;
        i_op    = inj_op;
        i_rs    = inj_rs;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busycyc"}, 64'(n_busy), 64'd33);
    chk({tag, "_idle"}, 64'(o_busy), 64'd0);
    chk({tag, "_sbq"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk({tag, "_hilo"}, {o_hi, o_lo}, exp);
      m_hi = exp.hi;
      m_lo = exp.lo;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input res_t exp_in);
    res_t exp;
    bit   iter;
    exp  = exp_in;
    iter = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
    if (op == OP_DIV || op == OP_DIVU) iter = 1'b1;
`else
    if (op == OP_DIV || op == OP_DIVU) exp = {m_hi, m_lo};
`endif
    sb_q.push_back(exp);
    issue(op, rs, rt, 1'b0);
    if (iter) begin
      wait_done(tag, -1, OP_NONE, 32'h0);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(o_done), 64'd0);
    end else begin
      @(negedge clk);
      chk({tag, "_nobusy"}, 64'(o_busy), 64'd0);
      chk({tag, "_nodone"}, 64'(o_done), 64'd0);
      exp = sb_q.pop_front();
      chk({tag, "_hilo"}, {o_hi, o_lo}, exp);
      m_hi = exp.hi;
      m_lo = exp.lo;
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    i_rstn  = 1'b0;
    i_start = 1'b0;
    i_op    = OP_NONE;
    i_rs    = '0;
    i_rt    = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", {30'b0, o_busy, o_done, o_hi, o_lo}, 64'd0);
    i_rstn = 1'b1;

    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mthi", OP_MTHI, 32'h1234_5678, 32'h0, {32'h1234_5678, m_lo});
    run_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'h0, {m_hi, 32'hCAFE_F00D});
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("divu_z", OP_DIVU, 32'h64, 32'd0, {32'h64, 32'hFFFF_FFFF});
    run_op("div_z", OP_DIV, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF});
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_op("none", OP_NONE, 32'h5555_5555, 32'h1, {m_hi, m_lo});
    run_op("rsvd", OP_RSVD, 32'h5555_5555, 32'h1, {m_hi, m_lo});

    // MTHI issued mid-MULT must be dropped; HI ends with the product.
    sb_q.push_back(model(OP_MULT, 32'h0000_1234, 32'hFFFF_FFFB, {m_hi, m_lo}));
    issue(OP_MULT, 32'h0000_1234, 32'hFFFF_FFFB, 1'b0);
    wait_done("mt_busy", 9, OP_MTHI, 32'hDEAD_BEEF);

    // Back-to-back: next op accepted in the done cycle.
    sb_q.push_back(model(OP_MULTU, 32'h89AB_CDEF, 32'h0123_4567, {m_hi, m_lo}));
    issue(OP_MULTU, 32'h89AB_CDEF, 32'h0123_4567, 1'b0);
    wait_done("b2b_a", -1, OP_NONE, 32'h0);
    sb_q.push_back(model(OP_MULT, 32'h8000_0000, 32'h8000_0000, {m_hi, m_lo}));
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("b2b_b", -1, OP_NONE, 32'h0);
    @(negedge clk);
    chk("b2b_pulse", 64'(o_done), 64'd0);

    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i == 5) ? 32'h0 : $urandom;
      run_op($sformatf("rnd%0d", i), op, a, b, model(op, a, b, {m_hi, m_lo}));
    end

    // Reset in the middle of a MULT discards it.
    sb_q.push_back(model(OP_MULT, 32'h7777_7777, 32'h3, {m_hi, m_lo}));
    issue(OP_MULT, 32'h7777_7777, 32'h3, 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_busy", 64'(o_busy), 64'd1);
    i_rstn = 1'b0;
    #1;
    chk("mid_rst", {30'b0, o_busy, o_done, o_hi, o_lo}, 64'd0);
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    #2;
    i_rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(o_busy), 64'd0);
    run_op("post_rst", OP_MULTU, 32'h0001_0000, 32'h0003_0000, {32'h3, 32'h0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
